// File: rtl/inference_pkg.sv
// inference_pkg: shared FSM state encoding and sample-count width for inference_engine.
package inference_pkg;

  localparam int NUM_SAMPLES_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PREF = 3'd2,
    RUN  = 3'd3,
    COMB = 3'd4,
    OUT  = 3'd5
  } state_t;

endpackage

// File: rtl/inference_lane.sv
// inference_lane: one dot-product lane (multiply, adder tree, accumulator, bias add).
// Define INFERENCE_SAT_EN to saturate accumulate and bias-add; otherwise they wrap.
module inference_lane #(
  parameter int inputBitwidth = 8,
  parameter int bitwidth      = 32,
  parameter int size          = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [inputBitwidth*size-1:0]     x,
  input  logic [inputBitwidth*size-1:0]     w,
  input  logic signed [inputBitwidth-1:0]   bias,
  input  logic                              acc_en,
  input  logic                              first,
  input  logic                              comb_en,
  output logic signed [bitwidth-1:0]        result
);

  // Wide enough that a full beat plus the accumulator never overflows before fit()
  localparam int WIDE = bitwidth + $clog2(size) + 2;
  localparam int PW   = 2 * inputBitwidth;

  logic signed [PW-1:0]       prod [size];
  logic signed [bitwidth-1:0] acc;
  logic signed [WIDE-1:0]     beat_sum;
  logic signed [WIDE-1:0]     acc_base;
  logic signed [WIDE-1:0]     acc_sum;
  logic signed [WIDE-1:0]     bias_sum;

  for (genvar j = 0; j < size; j++) begin : g_mul
    logic [inputBitwidth-1:0] xj;
    logic [inputBitwidth-1:0] wj;
    assign xj = x[j*inputBitwidth +: inputBitwidth];
    assign wj = w[j*inputBitwidth +: inputBitwidth];
    assign prod[j] = {{inputBitwidth{xj[inputBitwidth-1]}}, xj} *
                     {{inputBitwidth{wj[inputBitwidth-1]}}, wj};
  end

  // Reduce a wide intermediate to the lane width, clamping or wrapping
  function automatic logic signed [bitwidth-1:0] fit(input logic signed [WIDE-1:0] v);
`ifdef INFERENCE_SAT_EN
    logic signed [WIDE-1:0] max_w;
    logic signed [WIDE-1:0] min_w;
    max_w = {{(WIDE-bitwidth+1){1'b0}}, {(bitwidth-1){1'b1}}};
    min_w = {{(WIDE-bitwidth+1){1'b1}}, {(bitwidth-1){1'b0}}};
    if (v > max_w)      fit = {1'b0, {(bitwidth-1){1'b1}}};
    else if (v < min_w) fit = {1'b1, {(bitwidth-1){1'b0}}};
    else                fit = v[bitwidth-1:0];
`else
    fit = v[bitwidth-1:0];
`endif
  endfunction

  // Adder tree over the beat, then accumulator and bias sums at full precision
  always_comb begin
    beat_sum = '0;
    for (int j = 0; j < size; j++) beat_sum = beat_sum + WIDE'(prod[j]);
    acc_base = first ? '0 : WIDE'(acc);
    acc_sum  = acc_base + beat_sum;
    bias_sum = WIDE'(acc) + WIDE'(bias);
  end

  // Accumulate on each accepted beat; latch the biased result in COMB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (acc_en)  acc    <= fit(acc_sum);
      if (comb_en) result <= fit(bias_sum);
    end
  end

endmodule

// File: rtl/inference_engine.sv
// inference_engine: weight buffer, FSM and numUnit parallel dot-product lanes.
// Define INFERENCE_SAT_EN to make the lanes saturate instead of wrap.
module inference_engine
  import inference_pkg::*;
#(
  parameter int inputBitwidth = 8,
  parameter int bitwidth      = 32,
  parameter int size          = 4,
  parameter int numUnit       = 2,
  parameter int numCycle      = 4,
  parameter int logNumCycle   = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    load_w,
  input  logic [NUM_SAMPLES_W-1:0]                num_samples,
  input  logic [inputBitwidth*size*numUnit-1:0]   w_in,
  input  logic                                    w_valid,
  output logic                                    w_ready,
  input  logic [inputBitwidth*size-1:0]           x_in,
  input  logic                                    x_valid,
  output logic                                    x_ready,
  input  logic [inputBitwidth*numUnit-1:0]        bias,
  output logic [bitwidth*numUnit-1:0]             data_out,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    busy,
  output logic                                    done
);

  localparam int ROW_W  = inputBitwidth * size * numUnit;
  localparam int LANE_W = inputBitwidth * size;
  localparam logic [logNumCycle-1:0] LAST_ROW = logNumCycle'(numCycle - 1);

  state_t                   state, next_state;
  logic [logNumCycle-1:0]   waddr, raddr, chunk;
  logic [NUM_SAMPLES_W-1:0] sample_cnt, samples_q;
  logic [ROW_W-1:0]         wbuf [numCycle];
  logic [ROW_W-1:0]         rd_row;
  logic w_fire, x_fire, out_fire;
  logic last_row, last_chunk, last_sample, first_chunk, done_next;

  assign w_fire      = w_valid & w_ready;
  assign x_fire      = x_valid & x_ready;
  assign out_fire    = out_valid & out_ready;
  assign last_row    = (waddr == LAST_ROW);
  assign last_chunk  = (chunk == LAST_ROW);
  assign first_chunk = (chunk == '0);
  assign last_sample = ((sample_cnt + 1'b1) == samples_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state, handshake readies and done request
  always_comb begin
    next_state = state;
    w_ready    = 1'b0;
    x_ready    = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    done_next  = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        if (load_w)                 next_state = LOAD;
        else if (num_samples != '0) next_state = PREF;
        else                        done_next  = 1'b1;
      end
      LOAD: begin
        w_ready = 1'b1;
        if (w_fire && last_row) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end
      end
      PREF: next_state = RUN;
      RUN: begin
        x_ready = 1'b1;
        if (x_fire && last_chunk) next_state = COMB;
      end
      COMB: next_state = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_fire) begin
          if (last_sample) begin
            next_state = IDLE;
            done_next  = 1'b1;
          end else begin
            next_state = RUN;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Address, chunk and sample counters plus the registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr      <= '0;
      raddr      <= '0;
      chunk      <= '0;
      sample_cnt <= '0;
      samples_q  <= '0;
      done       <= 1'b0;
    end else begin
      done <= done_next;
      if (state == IDLE && start && !load_w) samples_q <= num_samples;
      if (w_fire) waddr <= last_row ? '0 : waddr + 1'b1;
      if (state == IDLE)                raddr <= '0;
      else if (state == PREF || x_fire) raddr <= (raddr == LAST_ROW) ? '0 : raddr + 1'b1;
      if (x_fire)   chunk      <= last_chunk ? '0 : chunk + 1'b1;
      if (out_fire) sample_cnt <= last_sample ? '0 : sample_cnt + 1'b1;
    end
  end

  // Weight buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_fire) wbuf[waddr] <= w_in;
  end

  // Registered read port, running one row ahead of the chunk being consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rd_row <= '0;
    else if (state == PREF || x_fire) rd_row <= wbuf[raddr];
  end

  for (genvar i = 0; i < numUnit; i++) begin : g_lane
    inference_lane #(
      .inputBitwidth(inputBitwidth),
      .bitwidth     (bitwidth),
      .size         (size)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .x      (x_in),
      .w      (rd_row[i*LANE_W +: LANE_W]),
      .bias   (bias[i*inputBitwidth +: inputBitwidth]),
      .acc_en (x_fire),
      .first  (first_chunk),
      .comb_en(state == COMB),
      .result (data_out[i*bitwidth +: bitwidth])
    );
  end

endmodule

// File: tb/tb_inference_engine.sv
// tb_inference_engine: randomized self-checking bench with a plain-arithmetic lane model.
module tb_inference_engine;

  localparam int BW = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, load_w;
  logic [15:0] num_samples;
  logic [63:0] w_in;
  logic        w_valid, w_ready;
  logic [31:0] x_in;
  logic        x_valid, x_ready;
  logic [15:0] bias;
  logic [31:0] data_out;
  logic        out_valid, out_ready, busy, done;

  int check_count = 0;
  int error_count = 0;

  byte w_model [4][2][4];
  byte x_data  [4][4][4];
  byte bias_v  [2];

  inference_engine #(
    .inputBitwidth(8), .bitwidth(BW), .size(4),
    .numUnit(2), .numCycle(4), .logNumCycle(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_w(load_w),
    .num_samples(num_samples), .w_in(w_in), .w_valid(w_valid), .w_ready(w_ready),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready), .bias(bias),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  function automatic longint fit(input longint v);
    longint lim;
    longint m;
    lim = longint'(1) <<< (BW - 1);
    m   = v;
`ifdef INFERENCE_SAT_EN
    if (v > lim - 1) m = lim - 1;
    else if (v < -lim) m = -lim;
`else
    m = v & ((lim <<< 1) - 1);
    if (m >= lim) m = m - (lim <<< 1);
`endif
    return m;
  endfunction

  function automatic longint model_lane(input int s, input int lane);
    longint acc;
    longint beat;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      beat = 0;
      for (int j = 0; j < 4; j++)
        beat += longint'(x_data[s][k][j]) * longint'(w_model[k][lane][j]);
      acc = fit(acc + beat);
    end
    return fit(acc + longint'(bias_v[lane]));
  endfunction

  function automatic longint lane_out(input int lane);
    logic [15:0] v;
    v = data_out[lane*16 +: 16];
    return longint'($signed(v));
  endfunction

  task automatic set_bias();
    for (int i = 0; i < 2; i++) bias[i*8 +: 8] = bias_v[i];
  endtask

  task automatic fill_weights(input bit rnd, input byte val);
    for (int r = 0; r < 4; r++)
      for (int l = 0; l < 2; l++)
        for (int j = 0; j < 4; j++)
          w_model[r][l][j] = rnd ? byte'($urandom_range(0, 255)) : val;
  endtask

  task automatic fill_x(input bit rnd, input byte val);
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 4; j++)
          x_data[s][k][j] = rnd ? byte'($urandom_range(0, 255)) : val;
  endtask

  task automatic load_weights(input bit gap);
    int n;
    start = 1; load_w = 1;
    @(posedge clk); #1;
    start = 0; load_w = 0;
    checkOutput("load_busy", busy, 1);
    for (int r = 0; r < 4; r++) begin
      for (int l = 0; l < 2; l++)
        for (int j = 0; j < 4; j++) w_in[(l*4+j)*8 +: 8] = w_model[r][l][j];
      w_valid = 1; n = 0;
      while (!w_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!w_ready) checkOutput("w_ready_timeout", 0, 1);
      @(posedge clk); #1;
      w_valid = 0; w_in = {$urandom, $urandom};
      if (gap && r < 3) begin @(posedge clk); #1; end
    end
    checkOutput("load_done", done, 1);
    checkOutput("load_idle", busy, 0);
    @(posedge clk); #1;
    checkOutput("load_done_pulse", done, 0);
  endtask

  task automatic send_x(input int s, input int k, input bit gap);
    int n;
    for (int j = 0; j < 4; j++) x_in[j*8 +: 8] = x_data[s][k][j];
    x_valid = 1; n = 0;
    while (!x_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!x_ready) checkOutput("x_ready_timeout", 0, 1);
    @(posedge clk); #1;
    x_valid = 0; x_in = $urandom;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input int nsamp, input bit gap, input int stall_sample, input int stall_cycles);
    int n;
    longint exp_v [2];
    start = 1; load_w = 0; num_samples = 16'(nsamp);
    @(posedge clk); #1;
    start = 0; num_samples = 16'($urandom);
    checkOutput("run_busy", busy, 1);
    checkOutput("pref_x_ready", x_ready, 0);
    for (int s = 0; s < nsamp; s++) begin
      for (int k = 0; k < 4; k++) send_x(s, k, gap);
      if (!gap) checkOutput("comb_out_valid", out_valid, 0);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      if (!gap) checkOutput("out_latency", n, 1);
      else if (!out_valid) checkOutput("out_valid_timeout", 0, 1);
      for (int i = 0; i < 2; i++) exp_v[i] = model_lane(s, i);
      if (s == stall_sample) begin
        for (int c = 0; c < stall_cycles; c++) begin
          checkOutput("stall_out_valid", out_valid, 1);
          checkOutput("stall_x_ready", x_ready, 0);
          for (int i = 0; i < 2; i++)
            checkOutput($sformatf("stall_lane%0d_s%0d", i, s), lane_out(i), exp_v[i]);
          @(posedge clk); #1;
        end
      end
      for (int i = 0; i < 2; i++)
        checkOutput($sformatf("data_lane%0d_s%0d", i, s), lane_out(i), exp_v[i]);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      if (s < nsamp - 1) checkOutput("mid_done", done, 0);
    end
    checkOutput("run_done", done, 1);
    checkOutput("run_idle", busy, 0);
    @(posedge clk); #1;
    checkOutput("run_done_pulse", done, 0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_w_ready"},   w_ready,   0);
    checkOutput({tag, "_x_ready"},   x_ready,   0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_done"},      done,      0);
    checkOutput({tag, "_data_out"},  data_out,  0);
  endtask

  initial begin
    rst_n = 0; start = 0; load_w = 0; num_samples = 0; w_in = '0; w_valid = 0;
    x_in = '0; x_valid = 0; bias = '0; out_ready = 0;
    repeat (2) @(posedge clk); #1;
    check_all_zero("reset");
    rst_n = 1;
    @(posedge clk); #1;

    $display("[TB] basic: w=1 x=2 bias=5");
    fill_weights(0, 8'sd1); load_weights(0);
    fill_x(0, 8'sd2); bias_v[0] = 5; bias_v[1] = 5; set_bias();
    applyStimulus(1, 0, -1, 0);
    checkOutput("basic_lane0", lane_out(0), 37);
    checkOutput("basic_lane1", lane_out(1), 37);

    $display("[TB] three samples with output stall");
    fill_weights(1, 0); load_weights(0);
    fill_x(1, 0); bias_v[0] = byte'($urandom); bias_v[1] = byte'($urandom); set_bias();
    applyStimulus(3, 0, 1, 5);

    $display("[TB] overflow: w=x=127");
    fill_weights(0, 8'sd127); load_weights(0);
    fill_x(0, 8'sd127); bias_v[0] = 0; bias_v[1] = 0; set_bias();
    applyStimulus(1, 0, -1, 0);
`ifdef INFERENCE_SAT_EN
    checkOutput("ovf_lane0", lane_out(0), 32767);
`else
    checkOutput("ovf_lane0", lane_out(0), -4080);
`endif

    $display("[TB] zero samples");
    start = 1; load_w = 0; num_samples = 0;
    @(posedge clk); #1;
    start = 0;
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput("zero_x_ready", x_ready, 0);
      checkOutput("zero_out_valid", out_valid, 0);
      checkOutput("zero_done_after", done, 0);
    end

    $display("[TB] start while busy, then reset during run");
    fill_weights(1, 0); load_weights(0);
    fill_x(1, 0); bias_v[0] = byte'($urandom); bias_v[1] = byte'($urandom); set_bias();
    start = 1; load_w = 0; num_samples = 2;
    @(posedge clk); #1;
    start = 0;
    send_x(0, 0, 0); send_x(0, 1, 0);
    start = 1; load_w = 1;
    @(posedge clk); #1;
    start = 0; load_w = 0;
    checkOutput("busy_start_x_ready", x_ready, 1);
    checkOutput("busy_start_w_ready", w_ready, 0);
    #2 rst_n = 0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check_all_zero("post_reset");
    fill_x(1, 0);
    applyStimulus(2, 0, -1, 0);

    $display("[TB] back-to-back versus gapped handshakes");
    fill_weights(1, 0); load_weights(0);
    fill_x(1, 0); bias_v[0] = byte'($urandom); bias_v[1] = byte'($urandom); set_bias();
    applyStimulus(2, 0, -1, 0);
    load_weights(1);
    applyStimulus(2, 1, -1, 0);

    $display("[TB] random runs");
    for (int t = 0; t < 3; t++) begin
      fill_weights(1, 0); load_weights(t[0]);
      fill_x(1, 0); bias_v[0] = byte'($urandom); bias_v[1] = byte'($urandom); set_bias();
      applyStimulus(int'($urandom_range(1, 4)), t[1], int'($urandom_range(0, 1)), 2);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
